link_frame_ctrl: RTL

Framed, checksummed UART link controller between the game logic and `uart_ff_buf`, taking over the byte path that `p1_and_p2_data` handles today. It periodically serialises the local player's 7-bit status word into a 3-byte frame and sends it through the UART TX FIFO. It parses incoming bytes from the RX FIFO and publishes the remote player's status word only after a frame validates. It supervises the link with a timeout, so remote `start`/`scoreboard` flags cannot stick high when the cable or the peer board drops.

---
 rtl/link_pkg.sv | 13 +
 rtl/link_rx_parser.sv | 43 ++++
 rtl/link_frame_ctrl.sv | 67 ++++++
 3 files changed

// File: rtl/link_pkg.sv
// link_pkg: frame constants, word field offsets and FSM encodings for the UART link
package link_pkg;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] CHK_MASK = 8'h5A;
  localparam int SB_BIT = 6;
  localparam int START_BIT = 5;
  localparam int DPOS_MSB = 4;
  typedef enum logic [1:0] {TX_IDLE, TX_SYNC, TX_DATA, TX_CHK} tx_state_t;
  typedef enum logic [1:0] {RX_HUNT, RX_SYNC, RX_DATA} rx_state_t;
  function automatic logic [7:0] chk_of(input logic [7:0] d);
    return d ^ CHK_MASK;
  endfunction
endpackage

// File: rtl/link_rx_parser.sv
// link_rx_parser: RX frame hunter/validator holding the last accepted remote word
module link_rx_parser
  import link_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_pop,
  input  logic [7:0] i_byte,
  input  logic       i_timeout,
  output logic       o_commit,
  output logic [6:0] o_word,
  output logic       o_valid,
  output logic [7:0] o_err_count
);
  rx_state_t r_state;
  logic [7:0] r_stored;
  logic w_sync, w_match, w_err;
  assign w_sync = i_byte == SYNC_BYTE;
  assign w_match = i_byte == chk_of(r_stored);
  assign o_commit = i_pop && r_state == RX_DATA && w_match;
  assign w_err = i_pop && ((r_state == RX_SYNC && i_byte[7] && !w_sync) || (r_state == RX_DATA && !w_match));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= RX_HUNT;
      r_stored <= '0;
      o_word <= '0;
      o_valid <= 1'b0;
      o_err_count <= '0;
    end else begin
      if (i_pop)
        case (r_state)
          RX_HUNT: r_state <= w_sync ? RX_SYNC : RX_HUNT;
          RX_SYNC: r_state <= !i_byte[7] ? RX_DATA : (w_sync ? RX_SYNC : RX_HUNT);
          default: r_state <= (!w_match && w_sync) ? RX_SYNC : RX_HUNT;
        endcase
      if (i_pop && r_state == RX_SYNC && !i_byte[7]) r_stored <= i_byte;
      if (w_err && o_err_count != 8'hFF) o_err_count <= o_err_count + 8'd1;
      o_valid <= o_commit;
      // a commit in the same cycle as the timeout keeps the fresh word
      if (o_commit) o_word <= r_stored[6:0];
      else if (i_timeout) o_word <= '0;
    end
endmodule

// File: rtl/link_frame_ctrl.sv
// link_frame_ctrl: periodic framed TX of the local word, validated RX of the remote word, link timeout
module link_frame_ctrl
  import link_pkg::*;
#(
  parameter int TX_PERIOD = 65000,
  parameter int TIMEOUT = 650000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] p1_in_data,
  input  logic       tx_full,
  output logic       wr_uart,
  output logic [7:0] w_data,
  input  logic       rx_empty,
  input  logic [7:0] r_data,
  output logic       rd_uart,
  output logic [6:0] p2_out_data,
  output logic       p2_valid,
  output logic       link_up,
  output logic [7:0] err_count
);
  localparam int PW = TX_PERIOD > 1 ? $clog2(TX_PERIOD) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  tx_state_t r_tx;
  logic [PW-1:0] r_per;
  logic [TW-1:0] r_to;
  logic [6:0] r_snap;
  logic r_pending;
  logic w_wrap, w_start, w_adv, w_to_hit, w_commit;
  assign w_wrap = r_per == PW'(TX_PERIOD - 1);
  // a wrap seen in TX_IDLE starts the frame directly so SYNC leaves the cycle after the wrap
  assign w_start = r_tx == TX_IDLE && (r_pending || w_wrap);
  assign w_adv = r_tx != TX_IDLE && !tx_full;
  assign w_to_hit = r_to == TW'(TIMEOUT - 1);
  assign wr_uart = w_adv;
  assign w_data = r_tx == TX_SYNC ? SYNC_BYTE :
                  r_tx == TX_DATA ? {1'b0, r_snap} :
                  r_tx == TX_CHK  ? chk_of({1'b0, r_snap}) : 8'h00;
  assign rd_uart = !rx_empty;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_tx <= TX_IDLE;
      r_per <= '0;
      r_to <= '0;
      r_snap <= '0;
      r_pending <= 1'b0;
      link_up <= 1'b0;
    end else begin
      r_per <= w_wrap ? '0 : r_per + PW'(1);
      r_pending <= !w_start && (r_pending || w_wrap);
      if (w_start) r_snap <= {p1_in_data[SB_BIT], p1_in_data[START_BIT], p1_in_data[DPOS_MSB:0]};
      r_tx <= w_start ? TX_SYNC : !w_adv ? r_tx : r_tx == TX_CHK ? TX_IDLE : tx_state_t'(r_tx + 2'd1);
      r_to <= w_commit ? '0 : r_to == TW'(TIMEOUT) ? r_to : r_to + TW'(1);
      link_up <= w_commit || (link_up && !w_to_hit);
    end
  link_rx_parser u_rx (
    .clk(clk),
    .rst(rst),
    .i_pop(rd_uart),
    .i_byte(r_data),
    .i_timeout(w_to_hit),
    .o_commit(w_commit),
    .o_word(p2_out_data),
    .o_valid(p2_valid),
    .o_err_count(err_count)
  );
endmodule
